// File: rtl/garage_door_pkg.sv
// Shared types for the garage door plant model.
//   door_state_e : FSM state encoding (3 bits).
//   door_dir_e   : direction remembered across a reversal dead time.
//   cnt_width()  : counter width needed to hold values 0..max_count-1 (minimum 1 bit).
package garage_door_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRunUp = 3'd1,
    StRunDn = 3'd2,
    StDead  = 3'd3,
    StFault = 3'd4
  } door_state_e;

  typedef enum logic {
    DirUp = 1'b0,
    DirDn = 1'b1
  } door_dir_e;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/door_step_prescaler.sv
// Free-running modulo counter shared by motion stepping and the reversal dead time.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   en_i    : count this cycle
//   clr_i   : force the count to 0 (wins over en_i)
//   term_i  : terminal count loaded by the caller (period - 1)
//   pulse_o : 1 for the enabled cycle whose count equals term_i; the count then wraps to 0
module door_step_prescaler #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             pulse_o
);

  logic [CNT_W-1:0] cnt_q;

  assign pulse_o = en_i && (cnt_q == term_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= pulse_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/garage_door_plant.sv
// Behavioural, synthesizable plant for the garage door: integrates motor commands into a
// door position and generates the limit switches that close the loop to the controller.
//   CLK, RST_n   : clock (rising edge), asynchronous active-low reset
//   Up_M, Dn_M   : motor commands from the controller
//   Up_max       : 1 when Position == TRAVEL_STEPS
//   Dn_max       : 1 when Position == 0
//   Position     : door position, 0 = closed
//   Moving       : 1 in the run states
//   Fault        : sticky, set when both commands are seen together; cleared only by reset
module garage_door_plant
  import garage_door_pkg::*;
#(
  parameter int unsigned TRAVEL_STEPS = 16,
  parameter int unsigned STEP_DIV     = 4,
  parameter int unsigned DEAD_CYCLES  = 2,
  parameter int unsigned POS_W        = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Up_M,
  input  logic             Dn_M,
  output logic             Up_max,
  output logic             Dn_max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);

  localparam int unsigned CntMax = (STEP_DIV > DEAD_CYCLES) ? STEP_DIV : DEAD_CYCLES;
  localparam int unsigned CntW   = cnt_width(CntMax);

  localparam logic [CntW-1:0]  StepTerm = CntW'(STEP_DIV - 1);
  localparam logic [CntW-1:0]  DeadTerm = CntW'(DEAD_CYCLES - 1);
  localparam logic [POS_W-1:0] TopPos   = POS_W'(TRAVEL_STEPS);
  localparam logic [POS_W-1:0] TopPosM1 = POS_W'(TRAVEL_STEPS - 1);
  localparam logic [POS_W-1:0] OnePos   = POS_W'(1);

  door_state_e      state_q, state_d;
  door_dir_e        pend_q, pend_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic            step_en, step_clr, step_pulse;
  logic [CntW-1:0] step_term;
  logic            up_only, dn_only, both_cmd, at_top, at_bot;

  assign up_only  = Up_M && !Dn_M;
  assign dn_only  = Dn_M && !Up_M;
  assign both_cmd = Up_M && Dn_M;
  assign at_top   = (pos_q == TopPos);
  assign at_bot   = (pos_q == '0);

  // One counter serves both the step period and the dead time.
  assign step_en   = (state_q == StRunUp) || (state_q == StRunDn) || (state_q == StDead);
  assign step_term = (state_q == StDead) ? DeadTerm : StepTerm;

  door_step_prescaler #(
    .CNT_W (CntW)
  ) u_prescaler (
    .clk_i   (CLK),
    .rst_ni  (RST_n),
    .en_i    (step_en),
    .clr_i   (step_clr),
    .term_i  (step_term),
    .pulse_o (step_pulse)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pos_d    = pos_q;
    step_clr = 1'b0;

    if (state_q != StFault && both_cmd) begin
      state_d  = StFault;
      step_clr = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          step_clr = 1'b1;
          // Commands that would drive past a limit are silently ignored.
          if (up_only && !at_top) begin
            state_d = StRunUp;
          end else if (dn_only && !at_bot) begin
            state_d = StRunDn;
          end
        end
        StRunUp: begin
          // A completed step always lands; the limit then outranks any command change.
          if (step_pulse) begin
            pos_d = pos_q + OnePos;
          end
          if (step_pulse && pos_q == TopPosM1) begin
            state_d  = StIdle;
            step_clr = 1'b1;
          end else if (dn_only) begin
            state_d  = StDead;
            pend_d   = DirDn;
            step_clr = 1'b1;
          end else if (!Up_M) begin
            state_d  = StIdle;
            step_clr = 1'b1;
          end
        end
        StRunDn: begin
          if (step_pulse) begin
            pos_d = pos_q - OnePos;
          end
          if (step_pulse && pos_q == OnePos) begin
            state_d  = StIdle;
            step_clr = 1'b1;
          end else if (up_only) begin
            state_d  = StDead;
            pend_d   = DirUp;
            step_clr = 1'b1;
          end else if (!Dn_M) begin
            state_d  = StIdle;
            step_clr = 1'b1;
          end
        end
        StDead: begin
          if (step_pulse) begin
            step_clr = 1'b1;
            // Re-check the limit so a reversal issued at a limit cannot over/underflow.
            if (pend_q == DirUp && up_only && !at_top) begin
              state_d = StRunUp;
            end else if (pend_q == DirDn && dn_only && !at_bot) begin
              state_d = StRunDn;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StFault: begin
          step_clr = 1'b1;
        end
        default: begin
          state_d  = StFault;
          step_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= StIdle;
      pend_q  <= DirUp;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pos_q   <= pos_d;
    end
  end

  assign Position = pos_q;
  assign Up_max   = at_top;
  assign Dn_max   = at_bot;
  assign Moving   = (state_q == StRunUp) || (state_q == StRunDn);
  assign Fault    = (state_q == StFault);

endmodule

// File: tb/tb_garage_door_plant.sv
module tb_garage_door_plant;

  logic       CLK;
  logic       RST_n;
  logic       Up_M;
  logic       Dn_M;
  logic       Up_max;
  logic       Dn_max;
  logic [7:0] Position;
  logic       Moving;
  logic       Fault;

  int vectors;
  int miscompares;

  typedef struct {
    bit         rst;
    bit         up;
    bit         dn;
    int         n;
    logic [7:0] pos;
    bit         upm;
    bit         dnm;
    bit         mov;
    bit         flt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  garage_door_plant #(
    .TRAVEL_STEPS (16),
    .STEP_DIV     (4),
    .DEAD_CYCLES  (2),
    .POS_W        (8)
  ) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .Up_M     (Up_M),
    .Dn_M     (Dn_M),
    .Up_max   (Up_max),
    .Dn_max   (Dn_max),
    .Position (Position),
    .Moving   (Moving),
    .Fault    (Fault)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] pos, input bit upm, input bit dnm,
                       input bit mov, input bit flt);
    vectors++;
    if (Position !== pos || Up_max !== upm || Dn_max !== dnm || Moving !== mov || Fault !== flt)
    begin
      miscompares++;
      $display("FAIL %s: got pos=%0d up_max=%b dn_max=%b moving=%b fault=%b, want pos=%0d up_max=%b dn_max=%b moving=%b fault=%b",
               name, Position, Up_max, Dn_max, Moving, Fault, pos, upm, dnm, mov, flt);
    end
  endtask

  task automatic add(input bit rst, input bit up, input bit dn, input int n, input int pos,
                     input bit upm, input bit dnm, input bit mov, input bit flt,
                     input string name);
    vec_t v;
    v.rst  = rst;
    v.up   = up;
    v.dn   = dn;
    v.n    = n;
    v.pos  = 8'(pos);
    v.upm  = upm;
    v.dnm  = dnm;
    v.mov  = mov;
    v.flt  = flt;
    v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST_n       = 1'b1;
    Up_M        = 1'b0;
    Dn_M        = 1'b0;

    //  rst up dn  n  pos um dm mv fl
    add(1, 0, 0, 0,  0, 0, 1, 0, 0, "reset_values");
    // Full travel up from closed.
    add(0, 1, 0, 1,  0, 0, 1, 1, 0, "up_enter");
    add(0, 1, 0, 4,  1, 0, 0, 1, 0, "up_first_step");
    add(0, 1, 0, 3,  1, 0, 0, 1, 0, "up_hold_between_steps");
    add(0, 1, 0, 1,  2, 0, 0, 1, 0, "up_second_step");
    add(0, 1, 0, 55, 15, 0, 0, 1, 0, "up_before_top");
    add(0, 1, 0, 1,  16, 1, 0, 0, 0, "up_reaches_top");
    add(0, 1, 0, 5,  16, 1, 0, 0, 0, "up_held_at_top");
    // Full travel down.
    add(0, 0, 1, 1,  16, 1, 0, 1, 0, "dn_enter");
    add(0, 0, 1, 4,  15, 0, 0, 1, 0, "dn_first_step");
    add(0, 0, 1, 59, 1, 0, 0, 1, 0, "dn_before_bottom");
    add(0, 0, 1, 1,  0, 0, 1, 0, 0, "dn_reaches_bottom");
    add(0, 0, 1, 20, 0, 0, 1, 0, 0, "dn_held_at_bottom");
    // Partial step discarded on release.
    add(0, 1, 0, 10, 2, 0, 0, 1, 0, "up_10_cycles");
    add(0, 0, 0, 1,  2, 0, 0, 0, 0, "up_release");
    add(0, 0, 0, 3,  2, 0, 0, 0, 0, "idle_hold");
    add(0, 1, 0, 4,  2, 0, 0, 1, 0, "partial_discarded");
    add(0, 1, 0, 1,  3, 0, 0, 1, 0, "full_step_after_restart");
    // Reversal through the dead time.
    add(0, 1, 0, 8,  5, 0, 0, 1, 0, "up_to_5");
    add(0, 0, 1, 1,  5, 0, 0, 0, 0, "reverse_dead_1");
    add(0, 0, 1, 1,  5, 0, 0, 0, 0, "reverse_dead_2");
    add(0, 0, 1, 1,  5, 0, 0, 1, 0, "reverse_run_dn");
    add(0, 0, 1, 3,  5, 0, 0, 1, 0, "reverse_dn_hold");
    add(0, 0, 1, 1,  4, 0, 0, 1, 0, "reverse_dn_step");
    // Limit reached on the same edge as a reversal request.
    add(1, 1, 0, 64, 15, 0, 0, 1, 0, "lim_approach");
    add(0, 0, 1, 1,  16, 1, 0, 0, 0, "lim_over_reversal");
    add(0, 0, 1, 1,  16, 1, 0, 1, 0, "lim_then_dn");
    add(0, 1, 0, 1,  16, 1, 0, 0, 0, "dn_reverse_to_dead");
    add(0, 0, 0, 2,  16, 1, 0, 0, 0, "dead_expiry_to_idle");
    add(0, 1, 0, 3,  16, 1, 0, 0, 0, "idle_ignores_up_at_top");
    // Fault while running up at position 3.
    add(1, 1, 0, 13, 3, 0, 0, 1, 0, "run_to_3");
    add(0, 1, 0, 2,  3, 0, 0, 1, 0, "run_at_3");
    add(0, 1, 1, 1,  3, 0, 0, 0, 1, "fault_set");
    add(0, 1, 0, 10, 3, 0, 0, 0, 1, "fault_ignores_up");
    add(0, 0, 1, 10, 3, 0, 0, 0, 1, "fault_ignores_dn");
    add(0, 1, 1, 3,  3, 0, 0, 0, 1, "fault_ignores_both");

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        Up_M  = 1'b0;
        Dn_M  = 1'b0;
        RST_n = 1'b0;
        tick(2);
        RST_n = 1'b1;
      end
      Up_M = vecs[i].up;
      Dn_M = vecs[i].dn;
      tick(vecs[i].n);
      check(vecs[i].name, vecs[i].pos, vecs[i].upm, vecs[i].dnm, vecs[i].mov, vecs[i].flt);
    end

    // Asynchronous reset out of FAULT, checked before any clock edge.
    Up_M = 1'b0;
    Dn_M = 1'b0;
    #2 RST_n = 1'b0;
    #1 check("async_reset_from_fault", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    RST_n = 1'b1;

    // Asynchronous reset mid-motion.
    Up_M = 1'b1;
    tick(7);
    check("motion_before_reset", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 RST_n = 1'b0;
    #1 check("async_reset_mid_motion", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    Up_M = 1'b0;
    tick(1);
    RST_n = 1'b1;
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
